matrix_slot_manager: RTL and testbench
======================================

// Module: matrix_slot_manager
// PURPOSE
//  Owns matrix storage bookkeeping: hands out a slot + BRAM base address to a requester, holds a
//  pending reservation until commit, then records dimensions and marks the slot valid. Sits
//  directly downstream of generate_mode (and other producer modes) on the alloc/commit interface;
//  consumers (display/compute modes) read slot metadata through a registered query port.
// PARAMETERS
//  ADDR_WIDTH  `BRAM_ADDR_WIDTH  BRAM word address width
//  NUM_SLOTS   8                 matrix slots managed (2..16)
//  SLOT_WORDS  256               words per slot (16x16 max); NUM_SLOTS*SLOT_WORDS <= 2**ADDR_WIDTH
// PORTS
//  clk           in   1           clock
//  rst_n         in   1           async active-low reset
//  alloc_req     in   1           allocation request (level; may stay high after grant)
//  alloc_valid   out  1           1-cycle grant pulse
//  alloc_slot    out  4           granted slot, stable from grant until next grant
//  alloc_addr    out  ADDR_WIDTH  granted base = alloc_slot*SLOT_WORDS
//  alloc_cancel  in   1           release pending reservation (timeout/abort)
//  commit_req    in   1           1-cycle commit strobe
//  commit_slot   in   4           slot being committed
//  commit_m      in   5           rows 1..16
//  commit_n      in   5           cols 1..16
//  commit_addr   in   ADDR_WIDTH  base address (checked against slot base)
//  del_req       in   1           1-cycle delete strobe
//  del_slot      in   4           slot to invalidate
//  qry_slot      in   4           query slot index
//  qry_valid     out  1           slot holds committed matrix (1-cycle latency)
//  qry_m, qry_n  out  5           committed dims (1-cycle latency; 0 when invalid)
//  qry_addr      out  ADDR_WIDTH  slot base (1-cycle latency)
//  valid_mask    out  NUM_SLOTS   per-slot valid bits
//  valid_count   out  5           number of valid slots
//  error_code    out  4           sticky last error (`ERR_* codes); cleared by next good commit
// BEHAVIOUR
//  Reset: all outputs 0; valid[], pending, dims cleared; victim pointer = 0; FSM = IDLE.
//  FSM IDLE -> GRANT on alloc_req=1 && !pending: pick slot (see policy), set pending, pend_slot;
//   GRANT: alloc_valid=1 for exactly one cycle -> HOLD.
//   HOLD: wait for alloc_req=0 before re-arming -> IDLE (requester's req may linger 1+ cycles;
//   a lingering high req must never produce a second grant).
//  alloc_req while pending (no commit/cancel yet): ignored, no grant, error_code=`ERR_BUSY.
//  Policy: lowest-index slot with !valid && !pending; if none, evict slot at victim pointer
//   (clear its valid), victim <= (victim+1) mod NUM_SLOTS. Victim advances only on eviction.
//  Grant latency: alloc_valid asserted the cycle after alloc_req first sampled high in IDLE.
//  Commit: accepted only if pending && commit_slot==pend_slot && commit_addr==base &&
//   1<=m,n<=16 -> valid[slot]=1, dims stored, pending=0, error_code=`ERR_NONE.
//   Otherwise: no state change except error_code=`ERR_COMMIT; pending kept.
//  alloc_cancel: pending=0, slot stays !valid; ignored when not pending.
//  Delete: del_slot<NUM_SLOTS clears valid and dims; del of pend_slot does nothing; out-of-range
//   slot -> `ERR_SLOT_RANGE.
//  Same-cycle priority: commit > cancel > delete > alloc sampling. Commit and delete of same slot
//   in one cycle: commit wins. Alloc sampled same cycle as commit sees post-commit state next cycle.
//  Query: registered; qry_slot>=NUM_SLOTS returns valid=0, m=n=0, addr=0. Query of a slot
//   updated this cycle returns new data on the following cycle (write-before-read).
//  valid_count = popcount(valid_mask), registered, updated 1 cycle after any change.
//  Address math: base = slot*SLOT_WORDS computed at ADDR_WIDTH bits; no wrap permitted (param check).
// STRUCTURE
//  matrix_pkg.vh: ERR_BUSY, ERR_COMMIT, ERR_SLOT_RANGE codes alongside existing ERR_*;
//   MAX_DIM=16 constant; slot index width 4.
//  Sub-module slot_picker (combinational): valid|pending vectors + victim -> slot, evict flag.
//  Metadata (m,n per slot) in register array, not BRAM.
// TESTING
//  1 reset, alloc_req 1 cycle -> alloc_valid pulse next cycle, slot 0, addr 0.
//  2 alloc_req held 4 cycles -> exactly one grant; commit slot0 m=3 n=4 addr=0 -> qry slot0 valid,3,4.
//  3 fill 8 slots, 9th alloc -> slot 0 evicted, valid_count 8->7, victim=1; 10th evicts slot 1.
//  4 commit slot2 while pending slot1, or m=0/n=17 -> `ERR_COMMIT, no valid change, pending kept.
//  5 alloc, alloc_cancel -> slot free; next alloc regrants same slot; alloc while pending -> `ERR_BUSY.
//  6 rst_n low mid-HOLD -> all cleared; del_slot=12 -> `ERR_SLOT_RANGE; qry_slot=9 -> zeros.

Source files
------------

// File: rtl/matrix_slot_manager_pkg.sv
// Shared constants, error codes and FSM state type for the matrix slot manager.
package matrix_slot_manager_pkg;

    localparam int SLOT_W  = 4;
    localparam int DIM_W   = 5;
    localparam int MAX_DIM = 16;

    localparam logic [3:0] ERR_NONE       = 4'd0;
    localparam logic [3:0] ERR_BUSY       = 4'd1;
    localparam logic [3:0] ERR_COMMIT     = 4'd2;
    localparam logic [3:0] ERR_SLOT_RANGE = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } alloc_state_t;

    function automatic logic dim_ok(input logic [DIM_W-1:0] d);
        return (d != '0) && (d <= DIM_W'(MAX_DIM));
    endfunction

endpackage

// File: rtl/matrix_slot_manager_slot_picker.sv
// Chooses the lowest-index free slot, falling back to the victim slot (evict) when all are busy.
module matrix_slot_manager_slot_picker
    import matrix_slot_manager_pkg::*;
#(
    parameter int NUM_SLOTS = 8
) (
    input  logic [NUM_SLOTS-1:0] busy,
    input  logic [SLOT_W-1:0]    victim,
    output logic [SLOT_W-1:0]    slot,
    output logic                 evict
);

    always_comb begin
        slot  = victim;
        evict = 1'b1;
        // Descending scan so the last hit is the lowest free index.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                slot  = SLOT_W'(i);
                evict = 1'b0;
            end
        end
    end

endmodule

// File: rtl/matrix_slot_manager.sv
// Slot/address allocator for matrix storage: reserve, commit, delete, and registered metadata query.
module matrix_slot_manager
    import matrix_slot_manager_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_SLOTS  = 8,
    parameter int SLOT_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_req,
    output logic                  alloc_valid,
    output logic [SLOT_W-1:0]     alloc_slot,
    output logic [ADDR_WIDTH-1:0] alloc_addr,
    input  logic                  alloc_cancel,
    input  logic                  commit_req,
    input  logic [SLOT_W-1:0]     commit_slot,
    input  logic [DIM_W-1:0]      commit_m,
    input  logic [DIM_W-1:0]      commit_n,
    input  logic [ADDR_WIDTH-1:0] commit_addr,
    input  logic                  del_req,
    input  logic [SLOT_W-1:0]     del_slot,
    input  logic [SLOT_W-1:0]     qry_slot,
    output logic                  qry_valid,
    output logic [DIM_W-1:0]      qry_m,
    output logic [DIM_W-1:0]      qry_n,
    output logic [ADDR_WIDTH-1:0] qry_addr,
    output logic [NUM_SLOTS-1:0]  valid_mask,
    output logic [4:0]            valid_count,
    output logic [3:0]            error_code
);

    if (NUM_SLOTS < 2 || NUM_SLOTS > 16 || NUM_SLOTS * SLOT_WORDS > (1 << ADDR_WIDTH)) begin : g_param_check
        $error("matrix_slot_manager: slot region does not fit the address space");
    end

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    function automatic logic [ADDR_WIDTH-1:0] slot_base(input logic [SLOT_W-1:0] s);
        return ADDR_WIDTH'(s) * ADDR_WIDTH'(SLOT_WORDS);
    endfunction

    alloc_state_t          state, state_nxt;
    logic                  pending, pend_post, pend_nxt;
    logic [SLOT_W-1:0]     pend_slot, pslot_nxt;
    logic [SLOT_W-1:0]     victim, victim_nxt;
    logic [NUM_SLOTS-1:0]  valid_post, valid_nxt;
    logic [DIM_W-1:0]      dim_m [NUM_SLOTS];
    logic [DIM_W-1:0]      dim_n [NUM_SLOTS];
    logic [DIM_W-1:0]      m_post [NUM_SLOTS];
    logic [DIM_W-1:0]      n_post [NUM_SLOTS];
    logic [DIM_W-1:0]      m_nxt [NUM_SLOTS];
    logic [DIM_W-1:0]      n_nxt [NUM_SLOTS];
    logic [SLOT_W-1:0]     alloc_slot_nxt;
    logic [ADDR_WIDTH-1:0] alloc_addr_nxt;
    logic [3:0]            err_nxt;
    logic                  commit_ok, del_ok, del_range_err;
    logic [SLOT_W-1:0]     pick_slot;
    logic                  pick_evict;
    logic                  qv_nxt;
    logic [DIM_W-1:0]      qm_nxt, qn_nxt;
    logic [4:0]            cnt_nxt;

    // Commit and delete resolved first; allocation then sees the post-commit/delete view.
    always_comb begin
        commit_ok = commit_req && pending && (commit_slot == pend_slot) &&
                    (commit_addr == slot_base(commit_slot)) &&
                    dim_ok(commit_m) && dim_ok(commit_n);
        del_range_err = del_req && (del_slot > LAST_SLOT);
        del_ok = del_req && !del_range_err &&
                 !(pending && del_slot == pend_slot) &&
                 !(commit_ok && commit_slot == del_slot);
        pend_post  = pending && !commit_ok && !alloc_cancel;
        valid_post = valid_mask;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            m_post[i] = dim_m[i];
            n_post[i] = dim_n[i];
            if (commit_ok && commit_slot == SLOT_W'(i)) begin
                valid_post[i] = 1'b1;
                m_post[i]     = commit_m;
                n_post[i]     = commit_n;
            end else if (del_ok && del_slot == SLOT_W'(i)) begin
                valid_post[i] = 1'b0;
                m_post[i]     = '0;
                n_post[i]     = '0;
            end
        end
    end

    matrix_slot_manager_slot_picker #(.NUM_SLOTS(NUM_SLOTS)) u_picker (
        .busy   (valid_post),
        .victim (victim),
        .slot   (pick_slot),
        .evict  (pick_evict)
    );

    always_comb begin
        state_nxt      = state;
        alloc_valid    = 1'b0;
        pend_nxt       = pend_post;
        pslot_nxt      = pend_slot;
        victim_nxt     = victim;
        valid_nxt      = valid_post;
        m_nxt          = m_post;
        n_nxt          = n_post;
        alloc_slot_nxt = alloc_slot;
        alloc_addr_nxt = alloc_addr;
        err_nxt        = error_code;
        if (commit_req)
            err_nxt = commit_ok ? ERR_NONE : ERR_COMMIT;
        else if (del_range_err)
            err_nxt = ERR_SLOT_RANGE;

        case (state)
            ST_IDLE: begin
                if (alloc_req && pend_post) begin
                    if (!commit_req && !del_range_err)
                        err_nxt = ERR_BUSY;
                end else if (alloc_req) begin
                    state_nxt      = ST_GRANT;
                    pend_nxt       = 1'b1;
                    pslot_nxt      = pick_slot;
                    alloc_slot_nxt = pick_slot;
                    alloc_addr_nxt = slot_base(pick_slot);
                    if (pick_evict) begin
                        for (int i = 0; i < NUM_SLOTS; i++) begin
                            if (pick_slot == SLOT_W'(i)) begin
                                valid_nxt[i] = 1'b0;
                                m_nxt[i]     = '0;
                                n_nxt[i]     = '0;
                            end
                        end
                        victim_nxt = (victim == LAST_SLOT) ? '0 : victim + 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                alloc_valid = 1'b1;
                state_nxt   = ST_HOLD;
            end
            ST_HOLD: begin
                if (!alloc_req)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Query and count read the next-state view so same-cycle updates are visible.
    always_comb begin
        qv_nxt  = 1'b0;
        qm_nxt  = '0;
        qn_nxt  = '0;
        cnt_nxt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            cnt_nxt = cnt_nxt + {4'b0, valid_nxt[i]};
            if (qry_slot == SLOT_W'(i) && valid_nxt[i]) begin
                qv_nxt = 1'b1;
                qm_nxt = m_nxt[i];
                qn_nxt = n_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pending     <= 1'b0;
            pend_slot   <= '0;
            victim      <= '0;
            valid_mask  <= '0;
            alloc_slot  <= '0;
            alloc_addr  <= '0;
            error_code  <= ERR_NONE;
            qry_valid   <= 1'b0;
            qry_m       <= '0;
            qry_n       <= '0;
            qry_addr    <= '0;
            valid_count <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                dim_m[i] <= '0;
                dim_n[i] <= '0;
            end
        end else begin
            state       <= state_nxt;
            pending     <= pend_nxt;
            pend_slot   <= pslot_nxt;
            victim      <= victim_nxt;
            valid_mask  <= valid_nxt;
            alloc_slot  <= alloc_slot_nxt;
            alloc_addr  <= alloc_addr_nxt;
            error_code  <= err_nxt;
            qry_valid   <= qv_nxt;
            qry_m       <= qm_nxt;
            qry_n       <= qn_nxt;
            qry_addr    <= (qry_slot <= LAST_SLOT) ? slot_base(qry_slot) : '0;
            valid_count <= cnt_nxt;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                dim_m[i] <= m_nxt[i];
                dim_n[i] <= n_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_matrix_slot_manager.sv
// Directed bench for matrix_slot_manager (12-bit addresses, 8 slots of 256 words).
module tb_matrix_slot_manager;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_req, alloc_valid, alloc_cancel;
    logic [3:0]  alloc_slot;
    logic [11:0] alloc_addr;
    logic        commit_req;
    logic [3:0]  commit_slot;
    logic [4:0]  commit_m, commit_n;
    logic [11:0] commit_addr;
    logic        del_req;
    logic [3:0]  del_slot, qry_slot;
    logic        qry_valid;
    logic [4:0]  qry_m, qry_n;
    logic [11:0] qry_addr;
    logic [7:0]  valid_mask;
    logic [4:0]  valid_count;
    logic [3:0]  error_code;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    matrix_slot_manager #(.ADDR_WIDTH(12), .NUM_SLOTS(8), .SLOT_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_slot(alloc_slot),
        .alloc_addr(alloc_addr), .alloc_cancel(alloc_cancel),
        .commit_req(commit_req), .commit_slot(commit_slot), .commit_m(commit_m),
        .commit_n(commit_n), .commit_addr(commit_addr),
        .del_req(del_req), .del_slot(del_slot),
        .qry_slot(qry_slot), .qry_valid(qry_valid), .qry_m(qry_m), .qry_n(qry_n),
        .qry_addr(qry_addr), .valid_mask(valid_mask), .valid_count(valid_count),
        .error_code(error_code)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic alloc_expect(input string tag, input int slot);
        alloc_req = 1'b1;
        tick(1);
        check({tag, "_valid"}, 32'(alloc_valid), 1);
        check({tag, "_slot"}, 32'(alloc_slot), slot);
        check({tag, "_addr"}, 32'(alloc_addr), slot * 256);
        alloc_req = 1'b0;
        tick(2);
    endtask

    task automatic commit(input int slot, input int m, input int n, input int addr);
        commit_req  = 1'b1;
        commit_slot = slot[3:0];
        commit_m    = m[4:0];
        commit_n    = n[4:0];
        commit_addr = addr[11:0];
        tick(1);
        commit_req  = 1'b0;
    endtask

    initial begin
        int grants;
        int fill_order[6];
        fill_order = '{1, 3, 4, 5, 6, 7};
        rst_n = 1'b0; alloc_req = 0; alloc_cancel = 0; commit_req = 0; commit_slot = 0;
        commit_m = 0; commit_n = 0; commit_addr = 0; del_req = 0; del_slot = 0; qry_slot = 0;
        tick(2);
        check("rst_alloc_valid", 32'(alloc_valid), 0);
        check("rst_mask", 32'(valid_mask), 0);
        check("rst_count", 32'(valid_count), 0);
        check("rst_err", 32'(error_code), 0);
        rst_n = 1'b1;
        tick(1);

        // single-cycle request: grant next cycle, slot 0
        alloc_req = 1'b1;
        tick(1);
        alloc_req = 1'b0;
        check("t1_valid", 32'(alloc_valid), 1);
        check("t1_slot", 32'(alloc_slot), 0);
        check("t1_addr", 32'(alloc_addr), 0);
        tick(1);
        check("t1_pulse_end", 32'(alloc_valid), 0);
        tick(1);
        qry_slot = 4'd0;
        commit(0, 3, 4, 0);
        check("t2_commit_err", 32'(error_code), 0);
        check("t2_mask", 32'(valid_mask), 8'h01);
        check("t2_count", 32'(valid_count), 1);
        check("t2_qv", 32'(qry_valid), 1);
        check("t2_qm", 32'(qry_m), 3);
        check("t2_qn", 32'(qry_n), 4);
        check("t2_qaddr", 32'(qry_addr), 0);

        // held request: exactly one grant
        grants = 0;
        alloc_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (alloc_valid) grants++;
        end
        alloc_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            if (alloc_valid) grants++;
        end
        check("t2_grants", 32'(grants), 1);
        check("t2_hold_slot", 32'(alloc_slot), 1);
        check("t2_hold_addr", 32'(alloc_addr), 256);
        check("t2_hold_err", 32'(error_code), 0);
        commit(1, 16, 16, 256);
        check("t2_commit16_mask", 32'(valid_mask), 8'h03);

        // bad commits keep the reservation
        alloc_expect("t4_alloc", 2);
        commit(3, 2, 2, 768);
        check("t4_wrong_slot_err", 32'(error_code), 2);
        check("t4_wrong_slot_mask", 32'(valid_mask), 8'h03);
        commit(2, 0, 2, 512);
        check("t4_m0_mask", 32'(valid_mask), 8'h03);
        commit(2, 2, 17, 512);
        check("t4_n17_mask", 32'(valid_mask), 8'h03);
        check("t4_n17_err", 32'(error_code), 2);
        commit(2, 2, 2, 0);
        check("t4_addr_mask", 32'(valid_mask), 8'h03);
        alloc_req = 1'b1;
        tick(1);
        check("t5_busy_err", 32'(error_code), 1);
        tick(1);
        check("t5_busy_nogrant", 32'(alloc_valid), 0);
        alloc_req = 1'b0;
        tick(1);

        // cancel frees slot 2, regranted next
        alloc_cancel = 1'b1;
        tick(1);
        alloc_cancel = 1'b0;
        check("t5_cancel_mask", 32'(valid_mask), 8'h03);
        alloc_expect("t5_regrant", 2);
        qry_slot = 4'd2;
        commit(2, 1, 1, 512);
        check("t5_commit_err", 32'(error_code), 0);
        check("t5_commit_mask", 32'(valid_mask), 8'h07);
        check("t5_qm", 32'(qry_m), 1);
        check("t5_qaddr", 32'(qry_addr), 512);

        // deletes
        del_req = 1'b1; del_slot = 4'd12;
        tick(1);
        check("t6_range_err", 32'(error_code), 3);
        check("t6_range_mask", 32'(valid_mask), 8'h07);
        del_slot = 4'd1; qry_slot = 4'd1;
        tick(1);
        del_req = 1'b0;
        check("t6_del_mask", 32'(valid_mask), 8'h05);
        check("t6_del_count", 32'(valid_count), 2);
        check("t6_del_qv", 32'(qry_valid), 0);
        check("t6_del_qm", 32'(qry_m), 0);
        check("t6_del_qaddr", 32'(qry_addr), 256);

        // fill remaining slots then evict
        foreach (fill_order[k]) begin
            alloc_expect($sformatf("t3_fill%0d", k), fill_order[k]);
            commit(fill_order[k], 2, 2, fill_order[k] * 256);
        end
        check("t3_full_mask", 32'(valid_mask), 8'hFF);
        check("t3_full_count", 32'(valid_count), 8);
        alloc_req = 1'b1;
        tick(1);
        alloc_req = 1'b0;
        check("t3_evict0_slot", 32'(alloc_slot), 0);
        check("t3_evict0_mask", 32'(valid_mask), 8'hFE);
        check("t3_evict0_count", 32'(valid_count), 7);
        tick(2);
        commit(0, 2, 2, 0);
        check("t3_refill_mask", 32'(valid_mask), 8'hFF);
        alloc_req = 1'b1;
        tick(1);
        alloc_req = 1'b0;
        check("t3_evict1_slot", 32'(alloc_slot), 1);
        check("t3_evict1_addr", 32'(alloc_addr), 256);
        check("t3_evict1_mask", 32'(valid_mask), 8'hFD);
        tick(2);
        alloc_cancel = 1'b1;
        tick(1);
        alloc_cancel = 1'b0;

        qry_slot = 4'd9;
        tick(1);
        check("t6_q9_valid", 32'(qry_valid), 0);
        check("t6_q9_m", 32'(qry_m), 0);
        check("t6_q9_n", 32'(qry_n), 0);
        check("t6_q9_addr", 32'(qry_addr), 0);

        // reset in HOLD with an error latched
        del_req = 1'b1; del_slot = 4'd15;
        tick(1);
        del_req = 1'b0;
        check("t6_err_before_rst", 32'(error_code), 3);
        qry_slot = 4'd3;
        alloc_req = 1'b1;
        tick(1);
        check("t6_pre_rst_slot", 32'(alloc_slot), 1);
        tick(1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_mask", 32'(valid_mask), 0);
        check("t6_rst_count", 32'(valid_count), 0);
        check("t6_rst_err", 32'(error_code), 0);
        check("t6_rst_slot", 32'(alloc_slot), 0);
        check("t6_rst_qv", 32'(qry_valid), 0);
        alloc_req = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        alloc_expect("t6_post_rst", 0);
        check("t6_post_rst_mask", 32'(valid_mask), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
